// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR: one shared signed MAC serves CH channels, each with its own
// TAPS-deep history ring. Optional output clamping + sticky sat_flag_o via FIR_SCHED_SAT_EN.

module fir_hist_ring #(
    parameter int IW   = 16,
    parameter int TAPS = 20,
    parameter int TW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [IW-1:0] sample_i,
    input  logic [TW-1:0] tap_i,
    output logic [IW-1:0] data_o
);
    logic [IW-1:0] mem_q [TAPS];
    logic [TW-1:0] wp_q, wp_d, rd_idx;
    logic [TW:0]   rd_sum;

    always_comb begin
        wp_d   = (wp_q == TW'(TAPS - 1)) ? '0 : wp_q + 1'b1;
        // (wp - tap) mod TAPS without a divider: bias by TAPS, subtract once
        rd_sum = {1'b0, wp_q} + (TW+1)'(TAPS) - {1'b0, tap_i};
        rd_idx = (rd_sum >= (TW+1)'(TAPS)) ? TW'(rd_sum - (TW+1)'(TAPS)) : TW'(rd_sum);
    end

    assign data_o = mem_q[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            wp_q        <= wp_d;
            mem_q[wp_d] <= sample_i;
        end
    end
endmodule

module fir_mac_sched #(
    parameter int IW   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 20,
    parameter int CH   = 2,
    parameter int AW   = 40,
    parameter int TW   = $clog2(TAPS),
    parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    ch_valid_i,
    input  logic [CH*IW-1:0] ch_data_i,
    output logic [CH-1:0]    ch_ready_o,
    input  logic             coef_we_i,
    input  logic [TW-1:0]    coef_addr_i,
    input  logic [CW-1:0]    coef_wdata_i,
    output logic             coef_ready_o,
    output logic             out_valid_o,
    output logic [CHW-1:0]   out_ch_o,
    output logic [IW-1:0]    out_data_o,
    output logic             busy_o
`ifdef FIR_SCHED_SAT_EN
   ,output logic             sat_flag_o
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_ROUND} state_e;

    state_e                 state_q, state_d;
    logic [CHW-1:0]         sel_q, last_q, gnt_idx;
    logic [IW-1:0]          sample_q;
    logic [TW-1:0]          k_q;
    logic signed [AW-1:0]   acc_q, prod_ext, rnd_sum;
    logic signed [CW-1:0]   coef_q [TAPS];
    logic [CH-1:0]          grant, push;
    logic [CH-1:0][IW-1:0]  hist_rd;
    logic signed [IW-1:0]   hist_sel;
    logic signed [IW+CW-1:0] prod;
    logic [IW-1:0]          res;
    logic                   out_valid_q;
    logic [CHW-1:0]         out_ch_q;
    logic [IW-1:0]          out_data_q;
    logic                   found, hs;

    for (genvar c = 0; c < CH; c++) begin : g_ring
        assign push[c] = (state_q == S_LOAD) && (sel_q == CHW'(c));
        fir_hist_ring #(.IW(IW), .TAPS(TAPS), .TW(TW)) u_ring (
            .clk      (clk),
            .reset    (reset),
            .push_i   (push[c]),
            .sample_i (sample_q),
            .tap_i    (k_q),
            .data_o   (hist_rd[c])
        );
    end

    // Round-robin: first requester after the last granted channel
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int off = 1; off <= CH; off++) begin
            if (!found && ch_valid_i[(int'(last_q) + off) % CH]) begin
                found   = 1'b1;
                gnt_idx = CHW'((int'(last_q) + off) % CH);
                grant[(int'(last_q) + off) % CH] = 1'b1;
            end
        end
    end

    assign ch_ready_o   = (state_q == S_IDLE && !reset) ? grant : '0;
    assign coef_ready_o = (state_q == S_IDLE) && !reset;
    assign hs           = |(ch_valid_i & ch_ready_o);
    assign busy_o       = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs) state_d = S_LOAD;
            S_LOAD:  state_d = S_MAC;
            S_MAC:   if (k_q == TW'(TAPS - 1)) state_d = S_ROUND;
            S_ROUND: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign hist_sel = hist_rd[sel_q];
    assign prod     = coef_q[k_q] * hist_sel;
    assign prod_ext = {{(AW-IW-CW){prod[IW+CW-1]}}, prod};
    assign rnd_sum  = acc_q + (AW'(1) << (CW - 2));

`ifdef FIR_SCHED_SAT_EN
    logic signed [AW-1:0] r;
    logic [AW-IW:0]       r_hi;
    logic                 ovf, sat_q;

    always_comb begin
        r    = rnd_sum >>> (CW - 1);
        r_hi = r[AW-1:IW-1];
        ovf  = ~((&r_hi) | ~(|r_hi));
        if (!ovf)          res = r[IW-1:0];
        else if (r[AW-1])  res = {1'b1, {(IW-1){1'b0}}};
        else               res = {1'b0, {(IW-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           sat_q <= 1'b0;
        else if (state_q == S_ROUND && ovf)  sat_q <= 1'b1;
    end
    assign sat_flag_o = sat_q;
`else
    assign res = IW'(rnd_sum >>> (CW - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q       <= '0;
            last_q      <= CHW'(CH - 1);
            sample_q    <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= (state_q == S_ROUND);
            case (state_q)
                S_IDLE: if (hs) begin
                    sel_q    <= gnt_idx;
                    last_q   <= gnt_idx;
                    sample_q <= ch_data_i[gnt_idx*IW +: IW];
                end
                S_LOAD: begin
                    acc_q <= '0;
                    k_q   <= '0;
                end
                S_MAC: begin
                    acc_q <= acc_q + prod_ext;
                    if (k_q != TW'(TAPS - 1)) k_q <= k_q + 1'b1;
                end
                S_ROUND: begin
                    out_data_q <= res;
                    out_ch_q   <= sel_q;
                end
                default: ;
            endcase
        end
    end

    // Coefficients are frozen outside IDLE so a MAC pass sees one consistent bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else if (coef_we_i && coef_ready_o && int'(coef_addr_i) < TAPS) begin
            coef_q[coef_addr_i] <= coef_wdata_i;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_data_o  = out_data_q;
endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: per-cycle compare against a dot-product model
// with per-channel history arrays, plus literal expectations for each scenario.

module tb_fir_mac_sched;
    localparam int IW = 16, CW = 16, TAPS = 20, CH = 2, AW = 40;
    localparam int TW = $clog2(TAPS), CHW = 1;

    logic             clk = 1'b0, reset = 1'b1;
    logic [CH-1:0]    ch_valid = '0;
    logic [CH*IW-1:0] ch_data = '0;
    logic [CH-1:0]    ch_ready_o;
    logic             coef_we = 1'b0;
    logic [TW-1:0]    coef_addr = '0;
    logic [CW-1:0]    coef_wdata = '0;
    logic             coef_ready_o, out_valid_o, busy_o;
    logic [CHW-1:0]   out_ch_o;
    logic [IW-1:0]    out_data_o;
`ifdef FIR_SCHED_SAT_EN
    logic             sat_flag_o;
`endif

    fir_mac_sched #(.IW(IW), .CW(CW), .TAPS(TAPS), .CH(CH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_ready_o(ch_ready_o),
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata),
        .coef_ready_o(coef_ready_o), .out_valid_o(out_valid_o), .out_ch_o(out_ch_o),
        .out_data_o(out_data_o), .busy_o(busy_o)
`ifdef FIR_SCHED_SAT_EN
       ,.sat_flag_o(sat_flag_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    longint cyc = 0;

    // model state
    int coef_m [TAPS];
    int hist_m [CH][TAPS];   // [c][0] is the newest sample
    int last_m = CH - 1;
    int busy_m = 0;          // cycles left before the scheduler is idle again
    bit sat_m = 0;
    typedef struct { longint cyc; int ch; logic [IW-1:0] data; bit sat; } exp_t;
    exp_t exp_q[$];
    int   obs_d[$];
    int   obs_c[$];

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void model_out(input int c, output logic [IW-1:0] d, output bit s);
        longint acc = 0, r;
        for (int k = 0; k < TAPS; k++) acc += longint'(coef_m[k]) * longint'(hist_m[c][k]);
        r = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        s = 0;
`ifdef FIR_SCHED_SAT_EN
        if (r > 32767)       begin d = 16'h7FFF; s = 1; end
        else if (r < -32768) begin d = 16'h8000; s = 1; end
        else d = r[IW-1:0];
`else
        d = r[IW-1:0];
`endif
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            coef_m[k] = 0;
            for (int c = 0; c < CH; c++) hist_m[c][k] = 0;
        end
        last_m = CH - 1; busy_m = 0; sat_m = 0;
        exp_q.delete();
    endfunction

    always @(negedge clk) begin
        bit exp_v;
        int g, c;
        exp_t e;
        logic [IW-1:0] d;
        bit s;
        cyc++;
        if (reset) begin
            chk("rst_ch_ready", ch_ready_o, 0);
            chk("rst_coef_ready", coef_ready_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_out_valid", out_valid_o, 0);
            chk("rst_out_ch", out_ch_o, 0);
            chk("rst_out_data", out_data_o, 0);
            model_reset();
        end else begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("out_valid", out_valid_o, exp_v);
            if (exp_v) begin
                e = exp_q.pop_front();
                sat_m |= e.sat;
                if (out_valid_o) begin
                    chk("out_ch", out_ch_o, e.ch);
                    chk("out_data", out_data_o, e.data);
                    obs_d.push_back(int'(out_data_o));
                    obs_c.push_back(int'(out_ch_o));
                end
            end
`ifdef FIR_SCHED_SAT_EN
            chk("sat_flag", sat_flag_o, sat_m);
`endif
            chk("busy", busy_o, busy_m != 0);
            chk("coef_ready", coef_ready_o, busy_m == 0);
            if (busy_m == 0) begin
                g = -1;
                for (int off = 1; off <= CH; off++) begin
                    c = (last_m + off) % CH;
                    if (g < 0 && ch_valid[c]) g = c;
                end
                chk("ch_ready", ch_ready_o, (g >= 0) ? (1 << g) : 0);
                if (coef_we && int'(coef_addr) < TAPS) coef_m[coef_addr] = int'($signed(coef_wdata));
                if (g >= 0) begin
                    for (int k = TAPS - 1; k > 0; k--) hist_m[g][k] = hist_m[g][k-1];
                    hist_m[g][0] = int'($signed(ch_data[g*IW +: IW]));
                    model_out(g, d, s);
                    e.cyc = cyc + TAPS + 3; e.ch = g; e.data = d; e.sat = s;
                    exp_q.push_back(e);
                    last_m = g;
                    busy_m = TAPS + 2;
                end
            end else begin
                chk("ch_ready_busy", ch_ready_o, 0);
                busy_m--;
            end
        end
    end

    function automatic int od(input int i);
        return (obs_d.size() > i) ? obs_d[i] : -1;
    endfunction
    function automatic int oc(input int i);
        return (obs_c.size() > i) ? obs_c[i] : -1;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        obs_d.delete(); obs_c.delete();
    endtask

    task automatic send(input int c, input int v);
        bit hs = 0;
        ch_valid[c] = 1'b1;
        ch_data[c*IW +: IW] = v[IW-1:0];
        for (int i = 0; i < 300 && !hs; i++) begin
            @(negedge clk); hs = ch_ready_o[c];
            @(posedge clk); #1;
        end
        if (!hs) chk("send_timeout", 0, 1);
        ch_valid[c] = 1'b0;
    endtask

    task automatic wcoef(input int a, input int v);
        bit ok = 0;
        coef_we = 1'b1; coef_addr = a[TW-1:0]; coef_wdata = v[CW-1:0];
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); ok = coef_ready_o;
            @(posedge clk); #1;
        end
        if (!ok) chk("wcoef_timeout", 0, 1);
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || busy_m != 0) && i < 600) begin
            @(posedge clk); #1; i++;
        end
        if (i >= 600) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_coef_ready", coef_ready_o, 1);
        chk("post_rst_out_data", out_data_o, 0);
        @(posedge clk); #1;

        // impulse response
        for (int k = 0; k < TAPS; k++) wcoef(k, 1000 * (k + 1));
        send(0, 32767);
        for (int j = 1; j < TAPS; j++) send(0, 0);
        drain();
        chk("imp_count", obs_d.size(), 20);
        chk("imp_0", od(0), 1000);
        chk("imp_15", od(15), 16000);
        chk("imp_16", od(16), 16999);
        chk("imp_19", od(19), 19999);

        // arbitration
        do_reset();
        wcoef(0, 32767);
        ch_data = {16'd200, 16'd100};
        ch_valid = 2'b11;
        for (int i = 0; i < 400 && obs_d.size() < 4; i++) begin @(posedge clk); #1; end
        ch_valid = 2'b00;
        drain();
        chk("arb_ch0", oc(0), 0);
        chk("arb_ch1", oc(1), 1);
        chk("arb_ch2", oc(2), 0);
        chk("arb_ch3", oc(3), 1);
        chk("arb_d0", od(0), 100);
        chk("arb_d1", od(1), 200);
        chk("arb_d2", od(2), 100);
        chk("arb_d3", od(3), 200);

        // coefficient lockout during MAC, then write in IDLE
        do_reset();
        wcoef(0, 32767);
        send(0, 100);
        repeat (4) @(posedge clk);
        #1 coef_we = 1'b1; coef_addr = '0; coef_wdata = '0;
        @(posedge clk); #1 coef_we = 1'b0;
        drain();
        chk("lock_mac", od(0), 100);
        wcoef(0, 0);
        send(0, 100);
        drain();
        chk("lock_idle", od(1), 0);

        // saturation / wrap of the rounded sum
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, 32767);
        for (int j = 0; j < TAPS; j++) send(0, 32767);
        drain();
        chk("sat_first", od(0), 32766);
`ifdef FIR_SCHED_SAT_EN
        chk("sat_last", od(19), 32767);
        chk("sat_flag_lit", sat_flag_o, 1);
`else
        chk("wrap_last", od(19), 16'hFFD8);
`endif

        // reset mid-MAC
        do_reset();
        wcoef(0, 32767);
        send(0, 5);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        obs_d.delete(); obs_c.delete();
        repeat (30) @(posedge clk);
        #1;
        chk("rstmac_no_out", obs_d.size(), 0);
        send(0, 32767);
        drain();
        chk("rstmac_coef_clear", od(0), 0);

        // ring pointer wrap
        do_reset();
        wcoef(19, 32767);
        for (int j = 0; j < 25; j++) send(0, 100 * (j + 1));
        drain();
        chk("wrap_18", od(18), 0);
        chk("wrap_19", od(19), 100);
        chk("wrap_24", od(24), 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_sched.md
# fir_mac_sched

Time-multiplexed FIR controller that shares a single signed multiply-accumulate unit among `CH` audio channels (e.g. PSG, FM left/right). It accepts one input sample per channel via valid/ready, sequences `TAPS` MAC cycles against a per-channel history ring and a shared coefficient bank, then emits one rounded, scaled output sample tagged with its channel. It sits between the per-chip sample-rate strobes and the resampler / mixer.

## Interface
- `IW`, 16: sample width, signed two's complement.
- `CW`, 16: coefficient width, signed Q1.(CW-1); 1.0 = 2^(CW-1).
- `TAPS`, 20: filter length, ≥2.
- `CH`, 2: number of requesting channels, ≥1.
- `AW`, 40: accumulator width, ≥ IW+CW+clog2(TAPS).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `ch_valid`  in  CH  per-channel sample request.
- `ch_data`  in  CH*IW  per-channel sample; channel i at bits [i*IW +: IW].
- `ch_ready`  out  CH  one-hot grant; combinational.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  clog2(TAPS)  coefficient index.
- `coef_wdata`  in  CW  coefficient value.
- `coef_ready`  out  1  high only in IDLE; writes are accepted only while high.
- `out_valid`  out  1  one-cycle pulse with result.
- `out_ch`  out  clog2(CH)  channel of the result.
- `out_data`  out  IW  filtered sample.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE → LOAD → MAC → ROUND → IDLE.
- IDLE:
  - Round-robin arbiter. Search starts at `last+1` mod CH; the first channel with `ch_valid` is granted via `ch_ready`.
  - A handshake (`ch_valid[i] & ch_ready[i]`) latches channel `i` and its sample, updates `last=i`, and moves to LOAD.
  - `ch_ready` is all-zero outside IDLE.
- LOAD:
  - Advance channel `i`'s write pointer (TAPS-1 wraps to 0) and write the sample at the new pointer.
  - Clear the accumulator and set tap index `k=0`.
- MAC, exactly TAPS cycles:
  - `acc += coef[k] * hist[i][(wp-k) mod TAPS]`, using a signed full-precision product sign-extended to AW.
  - `k` increments each cycle. On `k==TAPS-1` the state moves to ROUND.
- ROUND:
  - `r = (acc + 2^(CW-2)) >>> (CW-1)` (round half up, arithmetic shift).
  - `r` is resized to IW per the Configuration section and registered into `out_data`.
  - `out_ch=i`, `out_valid=1` for one cycle, then return to IDLE.
- Coefficient writes:
  - `coef_we & coef_ready` writes `coef[coef_addr]` at the clock edge.
  - `coef_we` while `!coef_ready` is dropped; no side effects.
  - `coef_addr ≥ TAPS` is ignored.
  - A handshake and a coefficient write in the same IDLE cycle are both performed. The new coefficient is used by that sample's MAC pass.
- Histories are independent per channel. A channel with no new sample keeps its history untouched.

## Timing
- Reset values:
  - `ch_ready=0`, `coef_ready=0` while reset is asserted; `coef_ready=1` from the first cycle after release.
  - `busy=0`, `out_valid=0`, `out_ch=0`, `out_data=0`.
  - All coefficients, histories and write pointers = 0; `last=CH-1`, so channel 0 wins first.
- Latency: handshake at edge n; LOAD at n+1; MAC at n+2…n+TAPS+1; ROUND at n+TAPS+2; `out_valid` is high during the cycle after edge n+TAPS+2.
- Throughput: one sample per TAPS+3 cycles aggregate. The earliest next handshake is in the cycle `out_valid` is high, because the state is IDLE again.
- `out_data`/`out_ch` hold their last value until the next ROUND.
- Reset asserted mid-operation aborts immediately. No `out_valid` is produced; histories and coefficients clear.
- With several channels valid continuously, grants rotate 0,1,…,CH-1,0. A channel that drops valid before its grant is skipped, and the grant is not held.

## Configuration
- `FIR_SCHED_SAT_EN` defined: `r` outside [-2^(IW-1), 2^(IW-1)-1] clamps to the nearest limit. The sticky output `sat_flag` sets on any clamp and clears only on reset.
- `FIR_SCHED_SAT_EN` undefined: `out_data = r[IW-1:0]` (two's-complement wrap), and the `sat_flag` port is absent.

## Test plan
- Impulse response: load `coef[k]=1000*(k+1)`, send 32767 then 19 zeros on ch0. The outputs must be `round(32767*1000*(k+1)/32768)`, i.e. 1000, 2000, …, 19999. Each `out_valid` arrives TAPS+3 cycles after its handshake.
- Arbitration: hold `ch_valid=2'b11` with ch0=100 and ch1=200, and `coef[0]=32767`, others 0. The `out_ch` sequence must be 0,1,0,1. `out_data` must be 100 and 200, and the two channel histories must not mix.
- Coefficient lockout: pulse `coef_we` (addr 0, data 0) during MAC. The write is ignored and the next result is unchanged. The same write in IDLE takes effect.
- Saturation: set all 20 coefficients to 32767 and feed 32767 repeatedly. With `FIR_SCHED_SAT_EN` the output is 32767 and `sat_flag=1`. Without it, the output equals the low 16 bits of the rounded sum.
- Reset mid-MAC: assert reset at MAC cycle 5. No `out_valid` is produced, all outputs are 0, and the coefficients read back 0, i.e. an impulse input then gives all-zero output.
- Wrap-around: send 25 samples on ch0 with a single nonzero coefficient at tap 19. Output j equals input j-19, which confirms the ring pointer wraps correctly from 19 to 0.
